// File: rtl/sar_scan_ctrl_if.sv
// SAR scan controller bus: scan control, comparator input, DAC drive and results.
// master = controller side, slave = front end / register side.
interface sar_scan_ctrl_if #(
   parameter int BITS = 10,
   parameter int NCH  = 4
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic            en;
   logic            cal;
   logic [NCH-1:0]  ch_mask;
   logic [1:0]      avg_log2;
   logic            cmp;
   logic [BITS-1:0] dac_code;
   logic [CHW-1:0]  ch_sel;
   logic            sample;
   logic            cal_mode;
   logic            busy;
   logic [BITS-1:0] result;
   logic [CHW-1:0]  result_ch;
   logic            valid;
   logic            cal_done;

   modport master (
      input  en, cal, ch_mask, avg_log2, cmp,
      output dac_code, ch_sel, sample, cal_mode, busy,
      output result, result_ch, valid, cal_done
   );

   modport slave (
      output en, cal, ch_mask, avg_log2, cmp,
      input  dac_code, ch_sel, sample, cal_mode, busy,
      input  result, result_ch, valid, cal_done
   );
endinterface

// File: rtl/sar_scan_ctrl.sv
// Round-robin SAR conversion controller with 2^k averaging and
// foreground comparator-offset calibration.
module sar_scan_ctrl #(
   parameter int BITS       = 10,
   parameter int NCH        = 4,
   parameter int SAMPLE_CYC = 2
) (
   input logic            wb_clk_i,
   input logic            wb_rst_i,
   sar_scan_ctrl_if.master bus
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW  = $clog2(SAMPLE_CYC + BITS + 1);
   localparam int AW  = BITS + 3;
   localparam logic [BITS-1:0] TOP = BITS'(1) << (BITS - 1);

   typedef enum logic [1:0] {IDLE, SAMPLE, CONV, OUT} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      rep, rep_n;
   logic [1:0]      avg_l, avg_l_n;
   logic            pass_cal, pass_cal_n;
   logic            fresh, fresh_n;
   logic [CHW-1:0]  ptr, ptr_n;
   logic [AW-1:0]   acc, acc_n;
   logic [BITS-1:0] offset, offset_n;

   logic [BITS-1:0] dac_q, dac_n;
   logic [CHW-1:0]  ch_sel_q, ch_sel_n;
   logic            sample_q, sample_n;
   logic            cal_mode_q, cal_mode_n;
   logic            busy_q, busy_n;
   logic [BITS-1:0] result_q, result_n;
   logic [CHW-1:0]  result_ch_q, result_ch_n;
   logic            valid_q, valid_n;
   logic            cal_done_q, cal_done_n;

   logic            decide;
   logic            start_res;
   logic            last_sample;
   logic            last_bit;
   logic            last_conv;
   logic [3:0]      nconv;
   logic [BITS-1:0] trial;
   logic [BITS-1:0] fin;
   logic [AW-1:0]   acc_fin;
   logic [BITS-1:0] avg;
   logic signed [BITS+1:0] corr;
   logic [BITS-1:0] sat;

   // Next enabled channel above p, wrapping; from IDLE start at channel 0.
   function automatic logic [CHW-1:0] next_ch(
      input logic [NCH-1:0] m,
      input logic [CHW-1:0] p,
      input logic           first
   );
      int base;
      int c;
      logic found;
      logic [CHW-1:0] r;
      base  = first ? NCH - 1 : int'(p);
      r     = p;
      found = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         c = base + i;
         if (c >= NCH) c = c - NCH;
         if (!found && m[c]) begin
            r     = CHW'(c);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   assign decide      = (state == IDLE) || (state == OUT);
   assign start_res   = bus.en && (|bus.ch_mask);
   assign last_sample = cnt == CW'(SAMPLE_CYC - 1);
   assign last_bit    = cnt == CW'(BITS - 1);
   assign nconv       = 4'd1 << avg_l;
   assign last_conv   = {1'b0, rep} == (nconv - 4'd1);
   assign trial       = TOP >> cnt;
   assign fin         = bus.cmp ? dac_q : (dac_q & ~trial);
   assign acc_fin     = acc + AW'(fin);
   assign avg         = BITS'(acc_fin >> avg_l);
   assign corr        = $signed({2'b00, avg})
                      - $signed({{2{offset[BITS-1]}}, offset});
   assign sat         = corr[BITS+1] ? '0
                      : corr[BITS]   ? '1
                      : corr[BITS-1:0];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         rep         <= '0;
         avg_l       <= '0;
         pass_cal    <= 1'b0;
         fresh       <= 1'b1;
         ptr         <= '0;
         acc         <= '0;
         offset      <= '0;
         dac_q       <= '0;
         ch_sel_q    <= '0;
         sample_q    <= 1'b0;
         cal_mode_q  <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         result_ch_q <= '0;
         valid_q     <= 1'b0;
         cal_done_q  <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         rep         <= rep_n;
         avg_l       <= avg_l_n;
         pass_cal    <= pass_cal_n;
         fresh       <= fresh_n;
         ptr         <= ptr_n;
         acc         <= acc_n;
         offset      <= offset_n;
         dac_q       <= dac_n;
         ch_sel_q    <= ch_sel_n;
         sample_q    <= sample_n;
         cal_mode_q  <= cal_mode_n;
         busy_q      <= busy_n;
         result_q    <= result_n;
         result_ch_q <= result_ch_n;
         valid_q     <= valid_n;
         cal_done_q  <= cal_done_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, OUT: begin
            if (bus.cal || start_res) state_n = SAMPLE;
            else                      state_n = IDLE;
         end
         SAMPLE: if (last_sample) state_n = CONV;
         CONV: begin
            if (last_bit) state_n = last_conv ? OUT : SAMPLE;
         end
      endcase
   end

   always_comb begin
      cnt_n       = (state_n == state) ? cnt + CW'(1) : '0;
      rep_n       = rep;
      avg_l_n     = avg_l;
      pass_cal_n  = pass_cal;
      fresh_n     = fresh;
      ptr_n       = ptr;
      acc_n       = acc;
      offset_n    = offset;
      dac_n       = '0;
      result_n    = result_q;
      result_ch_n = result_ch_q;
      valid_n     = 1'b0;
      cal_done_n  = 1'b0;

      if (decide) begin
         if (bus.cal) begin
            pass_cal_n = 1'b1;
            avg_l_n    = '0;
            acc_n      = '0;
            rep_n      = '0;
         end else if (start_res) begin
            pass_cal_n = 1'b0;
            avg_l_n    = bus.avg_log2;
            acc_n      = '0;
            rep_n      = '0;
            ptr_n      = next_ch(bus.ch_mask, ptr, fresh);
            fresh_n    = 1'b0;
         end else begin
            pass_cal_n = 1'b0;
            fresh_n    = 1'b1;
         end
      end

      if (state == SAMPLE && last_sample) dac_n = TOP;

      if (state == CONV) begin
         if (!last_bit) begin
            dac_n = fin | (trial >> 1);
         end else begin
            acc_n = acc_fin;
            rep_n = rep + 3'd1;
            if (last_conv) begin
               if (pass_cal) begin
                  offset_n   = fin - TOP;
                  cal_done_n = 1'b1;
               end else begin
                  result_n    = sat;
                  result_ch_n = ptr;
                  valid_n     = 1'b1;
               end
            end
         end
      end

      sample_n   = state_n == SAMPLE;
      busy_n     = state_n != IDLE;
      cal_mode_n = pass_cal_n
                 && (state_n == SAMPLE || state_n == CONV);
      ch_sel_n   = ptr_n;
   end

   assign bus.dac_code  = dac_q;
   assign bus.ch_sel    = ch_sel_q;
   assign bus.sample    = sample_q;
   assign bus.cal_mode  = cal_mode_q;
   assign bus.busy      = busy_q;
   assign bus.result    = result_q;
   assign bus.result_ch = result_ch_q;
   assign bus.valid     = valid_q;
   assign bus.cal_done  = cal_done_q;
endmodule
